// File: rtl/wb_burst_ram_slave.sv
// wb_burst_ram_slave: Wishbone B3 RAM responder with registered ack/err; CTI/BTE bursts only when WB_RAM_BURST_EN is defined
module wb_burst_ram_slave #(
    parameter int            dw       = 32,
    parameter int            aw       = 32,
    parameter int            DEPTH    = 1024,
    parameter logic [aw-1:0] BASE_ADR = '0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [aw-3:0] LIM = DEPTH[aw-3:0];

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

    state_t        state_q, state_d;
    logic          ack_q, ack_d, err_q, err_d, req, wr, unused_lsb;
    logic [dw-1:0] dat_q;
    logic [dw-1:0] mem [DEPTH];
    logic [aw-1:0] off;
    logic [aw-3:0] widx;
    logic [IW-1:0] radr;

    assign off        = wb_adr_i - BASE_ADR;
    assign widx       = off[aw-1:2];
    assign unused_lsb = ^off[1:0];
    assign req        = wb_cyc_i & wb_stb_i;
    assign wr         = ack_q & req & wb_we_i & (widx < LIM);
    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_rty_o   = 1'b0;

`ifdef WB_RAM_BURST_EN
    logic [aw-3:0] cnt_q, cnt_d, inc, wmask, nxt;

    assign inc   = cnt_q + {{(aw-3){1'b0}}, 1'b1};
    assign wmask = {{(aw-6){1'b0}}, wb_bte_i == 2'b11, wb_bte_i[1], |wb_bte_i, |wb_bte_i};
    assign nxt   = |wb_bte_i ? (cnt_q & ~wmask) | (inc & wmask) : inc;

    // burst address counter, held across wait states
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
`else
    logic unused_burst;
    assign unused_burst = ^{wb_cti_i, wb_bte_i};
`endif

    // next state, next termination flags and RAM read address (read-ahead in bursts)
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        radr    = widx[IW-1:0];
`ifdef WB_RAM_BURST_EN
        cnt_d   = cnt_q;
`endif
        if (!wb_cyc_i) state_d = IDLE;
        else if (state_q == IDLE) begin
            if (wb_stb_i) begin
`ifdef WB_RAM_BURST_EN
                state_d = wb_cti_i == 3'b010 ? BURST : CLASSIC;
                cnt_d   = widx;
`else
                state_d = CLASSIC;
`endif
                ack_d = widx < LIM;
                err_d = !(widx < LIM);
            end
        end
`ifdef WB_RAM_BURST_EN
        else if (state_q == BURST) begin
            radr = cnt_q[IW-1:0];
            if (wb_stb_i && (ack_q || err_q)) begin
                if (wb_cti_i == 3'b111 || wb_cti_i == 3'b000) state_d = IDLE;
                else begin
                    cnt_d = nxt;
                    radr  = nxt[IW-1:0];
                    ack_d = nxt < LIM;
                    err_d = !(nxt < LIM);
                end
            end else if (wb_stb_i) begin
                ack_d = cnt_q < LIM;
                err_d = !(cnt_q < LIM);
            end
        end
`endif
        else state_d = IDLE;
    end

    // state, registered terminations and read data; reset drops ack/err at once
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= mem[radr];
        end

    // byte-lane write on an acknowledged write beat; a same-word read sees the old word
    always_ff @(posedge wb_clk_i)
        for (int b = 0; b < 4; b++)
            if (wr && wb_sel_i[b]) mem[widx[IW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// tb_wb_burst_ram_slave: table-driven classic accesses plus burst, wait-state, range and reset sequences, scoreboarded
module tb_wb_burst_ram_slave;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef WB_RAM_BURST_EN
    localparam bit BEN = 1'b1;
`else
    localparam bit BEN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [31:0] adr = '0, dat_i = '0, dat_o;
    logic [3:0]  sel = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        ack, err, rty;
    int          checks = 0, errors = 0;

    typedef struct { logic e; logic [31:0] d; logic c; } exp_t;
    typedef struct { logic [31:0] off; logic w; logic [31:0] d; logic [3:0] s; logic e; logic [31:0] x; } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl [19];

    always #5 clk = ~clk;

    wb_burst_ram_slave #(.dw(32), .aw(32), .DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, x);
        end
    endtask

    // every terminated beat pops the oldest expectation
    always @(negedge clk)
        if (!rst && cyc && stb && (ack || err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra ack %b err %b adr %h", ack, err, adr);
            end else begin
                mon_e = sb.pop_front();
                chk("term_ack_err", {30'd0, ack, err}, mon_e.e ? 32'd1 : 32'd2);
                if (mon_e.c) chk("rdata", dat_o, mon_e.d);
            end
        end

    task automatic beat(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] c, input logic [1:0] b, input logic e, input logic [31:0] x,
                        output int waits);
        bit got = 1'b0;
        sb.push_back('{e, x, !w && !e});
        adr = a; we = w; dat_i = d; sel = s; cti = c; bte = b; cyc = 1'b1; stb = 1'b1;
        waits = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack || err) got = 1'b1;
            else waits++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout adr %h", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic pre(input int w);
        int wt;
        beat(BASE + w * 4, 1'b1, w, 4'hF, 3'b000, 2'b00, 1'b0, 32'd0, wt);
        idle();
    endtask

    task automatic burst(input int w0, input int n, input logic [1:0] b, input int gap);
        int m, w, wt;
        m = b == 2'b01 ? 3 : b == 2'b10 ? 7 : b == 2'b11 ? 15 : 0;
        for (int k = 0; k < n; k++) begin
            w = b == 2'b00 ? w0 + k : (w0 & ~m) | ((w0 + k) & m);
            if (k == gap) begin
                stb = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("gap_ack", {31'd0, ack}, 32'd0);
                end
            end
            beat(BASE + w * 4, 1'b0, 32'd0, 4'hF, k == n - 1 ? 3'b111 : 3'b010, b, w >= DEPTH, w, wt);
            chk("burst_wait", wt, (k == 0 || k == gap || !BEN) ? 32'd1 : 32'd0);
        end
        chk("burst_end", {30'd0, ack, err}, 32'd0);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int  wt;
        bit  got;
        tbl[0]  = '{32'h10,       1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        tbl[1]  = '{32'h10,       1'b0, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{32'h14,       1'b1, 32'h11223344, 4'hF, 1'b0, 32'h0};
        tbl[3]  = '{32'h14,       1'b1, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0};
        tbl[4]  = '{32'h14,       1'b0, 32'h0,        4'hF, 1'b0, 32'h11BB33DD};
        tbl[5]  = '{32'h18,       1'b1, 32'h12345678, 4'hF, 1'b0, 32'h0};
        tbl[6]  = '{32'h18,       1'b1, 32'hCAFEF00D, 4'h0, 1'b0, 32'h0};
        tbl[7]  = '{32'h18,       1'b0, 32'h0,        4'hF, 1'b0, 32'h12345678};
        tbl[8]  = '{32'h00,       1'b1, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0};
        tbl[9]  = '{DEPTH * 4,    1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
        tbl[10] = '{DEPTH * 4,    1'b0, 32'h0,        4'hF, 1'b1, 32'h0};
        tbl[11] = '{32'hFFFFFFFC, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0};
        tbl[12] = '{32'h00,       1'b0, 32'h0,        4'hF, 1'b0, 32'h5A5A5A5A};
        tbl[13] = '{(DEPTH-1)*4,  1'b1, 32'h600DF00D, 4'hF, 1'b0, 32'h0};
        tbl[14] = '{(DEPTH-1)*4,  1'b0, 32'h0,        4'hF, 1'b0, 32'h600DF00D};
        tbl[15] = '{32'h1C,       1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
        tbl[16] = '{32'h1C,       1'b1, 32'h00000000, 4'h8, 1'b0, 32'h0};
        tbl[17] = '{32'h1C,       1'b0, 32'h0,        4'hF, 1'b0, 32'h00FFFFFF};
        tbl[18] = '{32'h13,       1'b0, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF};

        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rty", {31'd0, rty}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            beat(BASE + tbl[i].off, tbl[i].w, tbl[i].d, tbl[i].s, 3'b000, 2'b00, tbl[i].e, tbl[i].x, wt);
            chk("classic_lat", wt, 32'd1);
            chk("classic_drop", {30'd0, ack, err}, 32'd0);
            idle();
        end

        for (int w = 0; w < 4; w++) pre(w);
        for (int w = 16; w < 32; w++) pre(w);
        for (int w = 40; w < 43; w++) pre(w);
        pre(DEPTH - 2);
        pre(DEPTH - 1);

        burst(2, 4, 2'b01, -1);
        burst(16, 8, 2'b00, 4);
        burst(21, 4, 2'b10, -1);
        burst(30, 4, 2'b11, -1);
        burst(DEPTH - 2, 3, 2'b00, -1);

        beat(BASE + 40 * 4, 1'b1, 32'hB0, 4'hF, 3'b010, 2'b00, 1'b0, 32'd0, wt);
        beat(BASE + 41 * 4, 1'b1, 32'hB1, 4'hF, 3'b010, 2'b00, 1'b0, 32'd0, wt);
        sb.push_back('{1'b0, 32'd0, 1'b0});
        adr = BASE + 42 * 4; dat_i = 32'hB2;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = ack || err;
        end
        chk("rst_beat_seen", {31'd0, got}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ack", {31'd0, ack}, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        chk("rst_mid_dat", dat_o, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int w = 40; w < 43; w++) begin
            beat(BASE + w * 4, 1'b0, 32'd0, 4'hF, 3'b000, 2'b00, 1'b0, w == 42 ? 32'd42 : 32'hB0 + w - 40, wt);
            chk("post_rst_lat", wt, 32'd1);
            idle();
        end
        burst(16, 2, 2'b00, -1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
